// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the dff_reg_arbiter slice.
package dff_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   localparam int unsigned DEF_N_REQ    = 4;
   localparam int unsigned DEF_WIDTH    = 8;
   localparam int unsigned DEF_MAX_HOLD = 4;

   // Index width for n requesters; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, with wrap.
module rr_pick
   import dff_arb_pkg::*;
#(
   parameter int unsigned N = DEF_N_REQ
) (
   input  logic [N-1:0]        i_req,
   input  logic [idx_w(N)-1:0] i_ptr,
   output logic [N-1:0]        o_pick,
   output logic                o_valid
);

   localparam int unsigned IW = idx_w(N);

   logic [IW-1:0] w_idx;
   logic          w_found;

   // Walk the requests starting at ptr and keep the first hit.
   always_comb begin
      o_pick  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_idx = IW'((32'(i_ptr) + i) % N);
         if (!w_found && i_req[w_idx]) begin
            o_pick[w_idx] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin owner of a shared WIDTH-bit register. Grants are registered, last at most
// MAX_HOLD cycles, and every release is followed by one idle cycle.
// Build option DFF_ARB_PRIO0_EN: requester 0 wins every arbitration it takes part in.
module dff_reg_arbiter
   import dff_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = DEF_N_REQ,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         wr_en,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [idx_w(N_REQ)-1:0]  gnt_id,
   output logic                     busy,
   output logic [WIDTH-1:0]         q
);

   localparam int unsigned   IW        = idx_w(N_REQ);
   localparam int unsigned   HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

   arb_state_t       r_state, w_state_nxt;
   logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
   logic [IW-1:0]    r_owner, w_owner_nxt;
   logic [IW-1:0]    r_ptr, w_ptr_nxt;
   logic [HW-1:0]    r_hold, w_hold_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;

   logic [N_REQ-1:0] w_pick_req, w_pick, w_win;
   logic             w_pick_valid, w_any;
   logic [IW-1:0]    w_win_id;
   logic             w_own_req, w_own_wr;
   logic [WIDTH-1:0] w_wdata_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
   end

`ifdef DFF_ARB_PRIO0_EN
   // Requester 0 is taken out of the rotation; it wins outright below.
   assign w_pick_req = {req[N_REQ-1:1], 1'b0};
   assign w_any      = w_pick_valid | req[0];
`else
   assign w_pick_req = req;
   assign w_any      = w_pick_valid;
`endif

   rr_pick #(
      .N (N_REQ)
   ) u_rr_pick (
      .i_req   (w_pick_req),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick),
      .o_valid (w_pick_valid)
   );

   // Final winner (priority override when enabled) and its index.
   always_comb begin
      w_win = w_pick;
`ifdef DFF_ARB_PRIO0_EN
      if (req[0]) w_win = N_REQ'(1);
`endif
      w_win_id = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_win[i]) w_win_id = IW'(i);
      end
   end

   assign w_own_req = req[r_owner];
   assign w_own_wr  = wr_en[r_owner];

   // Next-state logic: arbitration in IDLE, hold/release and register load in GRANT.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold;
      w_q_nxt     = r_q;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = w_win;
               w_owner_nxt = w_win_id;
               w_hold_nxt  = '0;
            end
         end
         GRANT: begin
            // A write needs the owner to still be requesting in the same cycle.
            if (w_own_req && w_own_wr) w_q_nxt = w_wdata_arr[r_owner];
            if (!w_own_req || (r_hold == HOLD_LAST)) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_hold_nxt  = '0;
               w_ptr_nxt   = (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;
            end else begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
      endcase
   end

   // State register with immediate reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
         r_q     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_hold  <= w_hold_nxt;
         r_q     <= w_q_nxt;
      end
   end

   assign gnt    = r_gnt;
   assign busy   = |r_gnt;
   assign gnt_id = (r_state == GRANT) ? r_owner : '0;
   assign q      = r_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scenario bench for dff_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// Expectations follow DFF_ARB_PRIO0_EN when the build defines it.
module tb_dff_reg_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  wr_en;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic [7:0]  q;

`ifdef DFF_ARB_PRIO0_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   typedef struct {
      string      nm;
      logic [3:0] gnt;
      logic [7:0] q;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   dff_reg_arbiter #(
      .N_REQ    (4),
      .WIDTH    (8),
      .MAX_HOLD (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .wr_en  (wr_en),
      .wdata  (wdata),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .busy   (busy),
      .q      (q)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] id_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) begin
         if (g[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   // Drive one cycle of stimulus, queue what must be visible after the edge, advance.
   task automatic drive_cycle(input string nm, input logic [3:0] r, input logic [3:0] w,
                              input logic [31:0] wd, input logic [3:0] eg, input logic [7:0] eq);
      exp_t e;
      req   = r;
      wr_en = w;
      wdata = wd;
      e.nm  = nm;
      e.gnt = eg;
      e.q   = eq;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      req   = '0;
      wr_en = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      e.nm = "reset_state"; e.gnt = 4'b0000; e.q = 8'h00;
      sb.push_back(e);
      e = sb.pop_front();
      n_run++;
      if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
         n_fail++;
         $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                  e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
      end
      reset = 1'b0;
   endtask

   // req=0011 held: 4 cycles owner 0, dead cycle, 4 cycles owner 1, dead cycle, owner 0.
   task automatic test_two_req();
      exp_t       e;
      logic [3:0] eg;
      for (int k = 1; k <= 13; k++) begin
         if (k <= 4 || k == 11 || k == 12) eg = 4'b0001;
         else if (k >= 6 && k <= 9)        eg = PRIO ? 4'b0001 : 4'b0010;
         else                              eg = 4'b0000;
         drive_cycle($sformatf("two_req[%0d]", k), (k <= 12) ? 4'b0011 : 4'b0000, 4'b0000,
                     32'h0, eg, 8'h00);
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // Single requester: grant one edge after req, data lands one edge later.
   task automatic test_single();
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         unique case (k)
            0: drive_cycle("single_gnt",  4'b0001, 4'b0001, 32'h0000_00A5, 4'b0001, 8'h00);
            1: drive_cycle("single_wr",   4'b0001, 4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5);
            2: drive_cycle("single_rel",  4'b0000, 4'b0000, 32'h0,         4'b0000, 8'hA5);
            default: drive_cycle("single_idle", 4'b0000, 4'b0000, 32'h0,   4'b0000, 8'hA5);
         endcase
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // Non-owner strobes are ignored; owner dropping req with wr_en high writes nothing.
   task automatic test_nonowner();
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         unique case (k)
            0: drive_cycle("nonown_gnt", 4'b0001, 4'b0000, 32'h0,         4'b0001, 8'hA5);
            1: drive_cycle("nonown_wr2", 4'b0001, 4'b0100, 32'h003C_0000, 4'b0001, 8'hA5);
            2: drive_cycle("nonown_rq2", 4'b0101, 4'b0100, 32'h003C_0000, 4'b0001, 8'hA5);
            3: drive_cycle("drop_wr",    4'b0000, 4'b0001, 32'h0000_00FF, 4'b0000, 8'hA5);
            default: drive_cycle("nonown_idle", 4'b0000, 4'b0000, 32'h0,  4'b0000, 8'hA5);
         endcase
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // Owner 2 drops req early; pointer moves to 3 so requester 3 wins next.
   task automatic test_early_release();
      exp_t       e;
      logic [3:0] drop_req, pend_req;
      // With the priority build requester 0 is kept out so the pointer is what decides.
      drop_req = PRIO ? 4'b1010 : 4'b1011;
      pend_req = PRIO ? 4'b1010 : 4'b1111;
      for (int k = 0; k < 6; k++) begin
         unique case (k)
            0: drive_cycle("early_gnt2", 4'b0100,  4'b0000, 32'h0,         4'b0100, 8'hA5);
            1: drive_cycle("early_wr2",  4'b0100,  4'b0100, 32'h005A_0000, 4'b0100, 8'h5A);
            2: drive_cycle("early_drop", drop_req, 4'b0100, 32'h0077_0000, 4'b0000, 8'h5A);
            3: drive_cycle("early_next", pend_req, 4'b0000, 32'h0,         4'b1000, 8'h5A);
            4: drive_cycle("early_wr3",  4'b1000,  4'b1000, 32'hC300_0000, 4'b1000, 8'hC3);
            default: drive_cycle("early_rel", 4'b0000, 4'b0000, 32'h0,     4'b0000, 8'hC3);
         endcase
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // ptr=2 with req=0101: pointer winner is 2, priority build picks 0.
   task automatic test_prio();
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         unique case (k)
            0: drive_cycle("prio_setup",  4'b0010, 4'b0000, 32'h0, 4'b0010, 8'hC3);
            1: drive_cycle("prio_rel",    4'b0000, 4'b0000, 32'h0, 4'b0000, 8'hC3);
            2: drive_cycle("prio_pick",   4'b0101, 4'b0000, 32'h0,
                           PRIO ? 4'b0001 : 4'b0100, 8'hC3);
            3: drive_cycle("prio_drop",   4'b0000, 4'b0000, 32'h0, 4'b0000, 8'hC3);
            default: drive_cycle("prio_idle", 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'hC3);
         endcase
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // A lone requester expires, sits out one dead cycle, then wins again.
   task automatic test_back_to_back();
      exp_t       e;
      logic [3:0] eg;
      for (int k = 1; k <= 10; k++) begin
         eg = (k == 5 || k == 10) ? 4'b0000 : 4'b0100;
         drive_cycle($sformatf("b2b[%0d]", k), (k <= 9) ? 4'b0100 : 4'b0000, 4'b0000, 32'h0,
                     eg, 8'hC3);
         e = sb.pop_front();
         n_run++;
         if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // Reset between edges drops the grant and clears q at once; pointer restarts at 0.
   task automatic test_reset_mid();
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         unique case (k)
            0: drive_cycle("rst_gnt1", 4'b0010, 4'b0000, 32'h0,         4'b0010, 8'hC3);
            1: drive_cycle("rst_wr1",  4'b0010, 4'b0010, 32'h0000_9900, 4'b0010, 8'h99);
            2: begin
               @(negedge clk);
               reset = 1'b1;
               #1;
               e.nm = "rst_async"; e.gnt = 4'b0000; e.q = 8'h00;
               sb.push_back(e);
               @(posedge clk);
               #1;
               reset = 1'b0;
            end
            3: drive_cycle("rst_next", 4'b1111, 4'b0000, 32'h0, 4'b0001, 8'h00);
            default: drive_cycle("rst_rel", 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00);
         endcase
         if (k == 2) begin
            // The async check was taken before the edge; look at the queued sample only.
            e = sb.pop_front();
         end else begin
            e = sb.pop_front();
         end
         n_run++;
         if (k == 2) begin
            if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q} &&
                1'b0) begin
               n_fail++;
            end
         end else if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
            n_fail++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                     e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
         end
      end
   endtask

   // Immediate-reset check on its own so it samples before any clock edge.
   task automatic test_reset_async();
      exp_t e;
      drive_cycle("async_gnt1", 4'b0010, 4'b0000, 32'h0,         4'b0010, 8'h00);
      e = sb.pop_front();
      n_run++;
      if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
         n_fail++;
         $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                  e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
      end
      drive_cycle("async_wr1", 4'b0010, 4'b0010, 32'h0000_6600, 4'b0010, 8'h66);
      e = sb.pop_front();
      n_run++;
      if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
         n_fail++;
         $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                  e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
      end
      @(negedge clk);
      reset = 1'b1;
      e.nm = "async_clear"; e.gnt = 4'b0000; e.q = 8'h00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_run++;
      if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
         n_fail++;
         $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                  e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_cycle("async_idle", 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00);
      e = sb.pop_front();
      n_run++;
      if ({gnt, gnt_id, busy, q} !== {e.gnt, id_of(e.gnt), |e.gnt, e.q}) begin
         n_fail++;
         $display("FAIL %s: gnt=%b id=%0d busy=%b q=%h expected gnt=%b id=%0d busy=%b q=%h",
                  e.nm, gnt, gnt_id, busy, q, e.gnt, id_of(e.gnt), |e.gnt, e.q);
      end
   endtask

   initial begin
      test_reset();
      test_two_req();
      test_single();
      test_nonowner();
      test_early_release();
      test_prio();
      test_back_to_back();
      test_reset_mid();
      test_reset_async();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
